// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter and its helpers:
// default byte width, FSM state encoding, header field layout and the
// command legality rule.
package router_pkg;

   localparam int DATA_W_DEF = 8;

   // Header layout: {payload_len, dest_addr} with the address in the low bits.
   localparam int ADDR_LSB = 0;
   localparam int ADDR_W   = 2;
   localparam int LEN_LSB  = ADDR_LSB + ADDR_W;

   // Router has three output ports; address 3 does not exist.
   localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_HEADER     = 3'd1,
      S_PAYLOAD    = 3'd2,
      S_PARITY     = 3'd3,
      S_WAIT_CHECK = 3'd4,
      S_DONE       = 3'd5
   } tx_state_e;

   // A command is legal when it targets a real port and carries payload.
   function automatic logic cmd_is_legal(input logic [ADDR_W-1:0] addr,
                                         input logic              len_nonzero);
      return (addr != ADDR_ILLEGAL) && len_nonzero;
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Signal bundle between the packet transmitter (master) and its environment
// (slave): command port, FWFT payload buffer port and router input port.
//
// Handshakes:
//   command : start is taken at a posedge where tx_ready=1; the result is
//             either the header on data_out one cycle later or a one-cycle
//             cmd_reject pulse.
//   router  : data_out/pkt_valid are held stable until a posedge with busy=0,
//             which accepts the byte; the next byte appears after that edge.
//   buffer  : pld_data is the buffer head; pld_rd=1 during a cycle means the
//             head is consumed at the next posedge.
interface router_pkt_tx_if #(
   parameter int DATA_W = router_pkg::DATA_W_DEF
);

   // command port
   logic                   start;
   logic [1:0]             dest_addr;
   logic [DATA_W-3:0]      payload_len;
   logic                   inject_err;
   logic                   tx_ready;
   logic                   tx_done;
   logic                   tx_err;
   logic                   cmd_reject;

   // payload buffer port
   logic [DATA_W-1:0]      pld_data;
   logic                   pld_rd;

   // router input port
   logic                   busy;
   logic                   err;
   logic [DATA_W-1:0]      data_out;
   logic                   pkt_valid;

   // FSM state for debug/observation
   router_pkg::tx_state_e  state_dbg;

   modport master (
      input  start, dest_addr, payload_len, inject_err,
      input  pld_data, busy, err,
      output tx_ready, tx_done, tx_err, cmd_reject,
      output pld_rd, data_out, pkt_valid, state_dbg
   );

   modport slave (
      output start, dest_addr, payload_len, inject_err,
      output pld_data, busy, err,
      input  tx_ready, tx_done, tx_err, cmd_reject,
      input  pld_rd, data_out, pkt_valid, state_dbg
   );

endinterface

// File: rtl/router_parity_gen.sv
// Byte-wide XOR accumulator: clear to zero, load a seed byte, or fold in a
// byte. Clear wins over load, load wins over xor. Shared with the router-side
// parity checker.
module router_parity_gen
   import router_pkg::*;
#(
   parameter int W = DATA_W_DEF
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clear,
   input  logic         load,
   input  logic         xor_en,
   input  logic [W-1:0] din,
   output logic [W-1:0] parity
);

   logic [W-1:0] parity_q;
   logic [W-1:0] parity_d;

   // Next accumulator value from the priority-ordered controls.
   always_comb begin
      parity_d = parity_q;
      if (clear) begin
         parity_d = '0;
      end else if (load) begin
         parity_d = din;
      end else if (xor_en) begin
         parity_d = parity_q ^ din;
      end
   end

   // Accumulator register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         parity_q <= '0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity = parity_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Source-side packet transmitter for the 1x3 router input port. Sends
// header -> payload bytes -> parity byte, stalling on router busy, then waits
// a few cycles and samples the router error flag to report packet status.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int CHECK_CYCLES = 3
) (
   input  logic            clock,
   input  logic            resetn,
   router_pkt_tx_if.master bus
);

   localparam int LEN_W  = DATA_W - LEN_LSB;
   localparam int WAIT_W = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CHECK_CYCLES - 1);

   tx_state_e          state_q,      state_d;
   logic [DATA_W-1:0]  data_out_q,   data_out_d;
   logic               pkt_valid_q,  pkt_valid_d;
   logic               tx_ready_q,   tx_ready_d;
   logic               tx_done_q,    tx_done_d;
   logic               tx_err_q,     tx_err_d;
   logic               cmd_reject_q, cmd_reject_d;
   logic [LEN_W-1:0]   len_q,        len_d;
   logic               inject_q,     inject_d;
   logic [LEN_W-1:0]   cnt_q,        cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;

   logic [DATA_W-1:0]  hdr;
   logic [DATA_W-1:0]  parity;
   logic [DATA_W-1:0]  par_din;
   logic               par_clear;
   logic               par_load;
   logic               par_xor;
   logic               pld_rd;

   // Running parity over header and payload bytes.
   router_parity_gen #(
      .W (DATA_W)
   ) u_parity (
      .clock  (clock),
      .resetn (resetn),
      .clear  (par_clear),
      .load   (par_load),
      .xor_en (par_xor),
      .din    (par_din),
      .parity (parity)
   );

   // Header byte built straight from the command inputs; once loaded into
   // data_out it stays there until accepted, so the address needs no copy.
   always_comb begin
      hdr = '0;
      hdr[ADDR_LSB +: ADDR_W] = bus.dest_addr;
      hdr[LEN_LSB  +: LEN_W]  = bus.payload_len;
   end

   // Next-state and next-output logic for the packet FSM.
   always_comb begin
      state_d      = state_q;
      data_out_d   = data_out_q;
      pkt_valid_d  = pkt_valid_q;
      tx_done_d    = 1'b0;
      tx_err_d     = tx_err_q;
      cmd_reject_d = 1'b0;
      len_d        = len_q;
      inject_d     = inject_q;
      cnt_d        = cnt_q;
      wait_cnt_d   = wait_cnt_q;
      pld_rd       = 1'b0;
      par_clear    = 1'b0;
      par_load     = 1'b0;
      par_xor      = 1'b0;
      par_din      = bus.pld_data;

      case (state_q)
         S_IDLE: begin
            // tx_ready_q is low for the first cycle after reset release.
            if (bus.start && tx_ready_q) begin
               if (cmd_is_legal(bus.dest_addr, |bus.payload_len)) begin
                  state_d     = S_HEADER;
                  len_d       = bus.payload_len;
                  inject_d    = bus.inject_err;
                  cnt_d       = '0;
                  data_out_d  = hdr;
                  pkt_valid_d = 1'b1;
                  tx_err_d    = 1'b0;
                  par_load    = 1'b1;
                  par_din     = hdr;
               end else begin
                  cmd_reject_d = 1'b1;
               end
            end
         end

         S_HEADER, S_PAYLOAD: begin
            if (!bus.busy) begin
               if (cnt_q < len_q) begin
                  // Pop the buffer head at the same edge that captures it.
                  data_out_d = bus.pld_data;
                  pld_rd     = 1'b1;
                  par_xor    = 1'b1;
                  cnt_d      = cnt_q + LEN_W'(1);
                  state_d    = S_PAYLOAD;
               end else begin
                  // Accumulator already includes the last payload byte.
                  data_out_d  = parity ^ {{(DATA_W-1){1'b0}}, inject_q};
                  pkt_valid_d = 1'b0;
                  state_d     = S_PARITY;
               end
            end
         end

         S_PARITY: begin
            if (!bus.busy) begin
               data_out_d = '0;
               wait_cnt_d = '0;
               state_d    = S_WAIT_CHECK;
            end
         end

         S_WAIT_CHECK: begin
            // Give the router time to raise its error flag.
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         S_DONE: begin
            tx_done_d = 1'b1;
            tx_err_d  = bus.err;
            par_clear = 1'b1;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      tx_ready_d = (state_d == S_IDLE);
   end

   // All FSM state, counters and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         data_out_q   <= '0;
         pkt_valid_q  <= 1'b0;
         tx_ready_q   <= 1'b0;
         tx_done_q    <= 1'b0;
         tx_err_q     <= 1'b0;
         cmd_reject_q <= 1'b0;
         len_q        <= '0;
         inject_q     <= 1'b0;
         cnt_q        <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         data_out_q   <= data_out_d;
         pkt_valid_q  <= pkt_valid_d;
         tx_ready_q   <= tx_ready_d;
         tx_done_q    <= tx_done_d;
         tx_err_q     <= tx_err_d;
         cmd_reject_q <= cmd_reject_d;
         len_q        <= len_d;
         inject_q     <= inject_d;
         cnt_q        <= cnt_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.pkt_valid  = pkt_valid_q;
   assign bus.tx_ready   = tx_ready_q;
   assign bus.tx_done    = tx_done_q;
   assign bus.tx_err     = tx_err_q;
   assign bus.cmd_reject = cmd_reject_q;
   assign bus.pld_rd     = pld_rd;
   assign bus.state_dbg  = state_q;

endmodule
